async_fifo_rd_ctrl: RTL and testbench

Read-side control for the dual-clock FIFO. It synchronises the write-domain Gray pointer into rclk through a parametrised N-stage flop chain. It also maintains the read pointer, and generates the registered empty flag, fill level, almost-empty flag and sticky underflow error. It sits between the write-side control (which supplies wptr_g) and the FIFO RAM read port (which consumes raddr). The write-side control consumes rptr_g.

---
 rtl/async_fifo_pkg.sv | 25 ++
 rtl/sync_bus_nff.sv | 31 +++
 rtl/async_fifo_rd_ctrl.sv | 106 ++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared helpers for both halves of the dual-clock FIFO: Gray/binary conversion
// and the legal synchroniser depth range.
package async_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Widest pointer the helpers accept; narrower callers zero-extend and truncate.
  localparam int PTR_W_MAX = 32;

  // Zero-extended upper bits contribute nothing, so one body serves every width.
  function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
    logic [PTR_W_MAX-1:0] bin;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_bus_nff.sv
// Generic WIDTH x STAGES flop-chain synchroniser; the output is the last stage only.
module sync_bus_nff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every stage is reset, not just the last, so no stale pointer can ripple out after reset.
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let each stage take its neighbour's old value, forming a true shift chain.
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side control of the dual-clock FIFO: wptr synchroniser, read pointer, empty/level flags.
// Level and almost-empty arithmetic is built only when ASYNC_FIFO_RD_LEVEL_EN is defined.
module async_fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_g,
  input  logic                rinc,
  output logic [ADDRSIZE:0]   rptr_g,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PTR_W = ADDRSIZE + 1;

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync_stages
    $error("async_fifo_rd_ctrl: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end

  if (AE_THRESH < 0 || AE_THRESH > (1 << ADDRSIZE)) begin : g_bad_ae_thresh
    $error("async_fifo_rd_ctrl: AE_THRESH=%0d outside 0..%0d", AE_THRESH, 1 << ADDRSIZE);
  end

  logic [PTR_W-1:0]    rq_wptr;
  logic [PTR_W-1:0]    rbin_q, rbin_d;
  logic [PTR_W-1:0]    rptr_q, rgray_d;
  logic [ADDRSIZE-1:0] raddr_q;
  logic [PTR_W-1:0]    level_q, level_d;
  logic                rempty_q, rempty_d;
  logic                rae_q, rae_d;
  logic                runderflow_q;
  logic                pop;

  sync_bus_nff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .d_i   (wptr_g),
    .q_o   (rq_wptr)
  );

  always_comb begin
    // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
    pop      = rinc & ~rempty_q;
    rbin_d   = rbin_q + PTR_W'(pop);
    rgray_d  = PTR_W'(bin2gray(PTR_W_MAX'(rbin_d)));
    // Full-width compare: the extra MSB keeps a full FIFO from looking empty.
    rempty_d = (rgray_d == rq_wptr);
  end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_THRESH);

  logic [PTR_W-1:0] wbin_sync;

  always_comb begin
    wbin_sync = PTR_W'(gray2bin(PTR_W_MAX'(rq_wptr)));
    level_d   = wbin_sync - rbin_d;
    rae_d     = (level_d <= AE_LVL);
  end
`else
  assign level_d = '0;
  assign rae_d   = rempty_d;
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      raddr_q      <= '0;
      rempty_q     <= 1'b1;
      rae_q        <= 1'b1;
      level_q      <= '0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      raddr_q  <= rbin_d[ADDRSIZE-1:0];
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      level_q  <= level_d;
      if (rinc && rempty_q) begin
        runderflow_q <= 1'b1;
      end
    end
  end

  assign rptr_g        = rptr_q;
  assign raddr         = raddr_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = rae_q;
  assign rlevel        = level_q;
  assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: counts writes/reads as plain integers and derives the
// expected flags from the synchroniser delay; honours ASYNC_FIFO_RD_LEVEL_EN like the RTL.
module tb_async_fifo_rd_ctrl;

  localparam int ADDRSIZE    = 4;
  localparam int SYNC_STAGES = 3;
  localparam int AE_THRESH   = 2;
  localparam int DEPTH       = 1 << ADDRSIZE;

  logic       rclk   = 1'b0;
  logic       rrst_n = 1'b1;
  logic [4:0] wptr_g = '0;
  logic       rinc   = 1'b0;
  logic [4:0] rptr_g;
  logic [3:0] raddr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: total writes issued, total pops accepted, visible fill level.
  int w_tot;
  int rd_tot;
  int m_level;
  bit m_empty;
  bit m_uflow;
  int wq[$];

  async_fifo_rd_ctrl #(
    .ADDRSIZE    (ADDRSIZE),
    .SYNC_STAGES (SYNC_STAGES),
    .AE_THRESH   (AE_THRESH)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .wptr_g        (wptr_g),
    .rinc          (rinc),
    .rptr_g        (rptr_g),
    .raddr         (raddr),
    .rempty        (rempty),
    .ralmost_empty (ralmost_empty),
    .rlevel        (rlevel),
    .runderflow    (runderflow)
  );

  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray_of(input int n);
    logic [4:0] b;
    b = 5'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  function automatic int exp_level();
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    return m_level;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_ae();
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    return m_level <= AE_THRESH;
`else
    return m_empty;
`endif
  endfunction

  task automatic model_reset();
    w_tot   = 0;
    rd_tot  = 0;
    m_level = 0;
    m_empty = 1'b1;
    m_uflow = 1'b0;
    wq.delete();
    for (int i = 0; i < SYNC_STAGES; i++) wq.push_back(0);
  endtask

  task automatic set_w(input int n);
    w_tot  = n;
    wptr_g = gray_of(n);
  endtask

  // One rclk edge: a write count sampled now is first used SYNC_STAGES edges later.
  task automatic tick();
    int seen_w;
    @(posedge rclk);
    seen_w = wq.pop_front();
    wq.push_back(w_tot);
    if (rinc && m_empty) m_uflow = 1'b1;
    if (rinc && !m_empty) rd_tot++;
    m_level = seen_w - rd_tot;
    m_empty = (m_level == 0);
    #1;
  endtask

  task automatic apply_reset();
    rinc   = 1'b0;
    rrst_n = 1'b0;
    model_reset();
    set_w(0);
    repeat (2) @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  task automatic test_reset();
    rinc   = 1'b0;
    wptr_g = 5'b00011;
    #2 rrst_n = 1'b0;
    #1;
    n_checks += 6;
    if (rempty !== 1'b1)        begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
    if (ralmost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ralmost_empty: got %b expected 1", ralmost_empty); end
    if (rlevel !== 5'd0)        begin n_fail++; $display("FAIL reset_rlevel: got %0d expected 0", rlevel); end
    if (raddr !== 4'd0)         begin n_fail++; $display("FAIL reset_raddr: got %0d expected 0", raddr); end
    if (rptr_g !== 5'd0)        begin n_fail++; $display("FAIL reset_rptr_g: got %b expected 00000", rptr_g); end
    if (runderflow !== 1'b0)    begin n_fail++; $display("FAIL reset_runderflow: got %b expected 0", runderflow); end
    // Edges while held in reset must not move anything either.
    repeat (3) @(posedge rclk);
    #1;
    n_checks += 2;
    if (rempty !== 1'b1)   begin n_fail++; $display("FAIL reset_hold_rempty: got %b expected 1", rempty); end
    if (rlevel !== 5'd0)   begin n_fail++; $display("FAIL reset_hold_rlevel: got %0d expected 0", rlevel); end
    apply_reset();
  endtask

  task automatic test_sync_latency();
    int fall_edge = -1;
    apply_reset();
    set_w(1);
    for (int e = 1; e <= SYNC_STAGES + 3; e++) begin
      tick();
      n_checks += 2;
      if (rempty !== m_empty) begin n_fail++; $display("FAIL sync_rempty edge %0d: got %b expected %b", e, rempty, m_empty); end
      if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL sync_rlevel edge %0d: got %0d expected %0d", e, rlevel, exp_level()); end
      if (rempty === 1'b0 && fall_edge < 0) fall_edge = e;
    end
    n_checks++;
    if (fall_edge != SYNC_STAGES + 1) begin
      n_fail++; $display("FAIL sync_latency: rempty fell at edge %0d expected %0d", fall_edge, SYNC_STAGES + 1);
    end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 1; i <= DEPTH + SYNC_STAGES; i++) begin
      if (i <= DEPTH) set_w(i);
      tick();
      n_checks += 2;
      if (rempty !== m_empty) begin n_fail++; $display("FAIL fill_rempty step %0d: got %b expected %b", i, rempty, m_empty); end
      if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL fill_rlevel step %0d: got %0d expected %0d", i, rlevel, exp_level()); end
    end
`ifdef ASYNC_FIFO_RD_LEVEL_EN
    n_checks++;
    if (rlevel !== 5'd16) begin n_fail++; $display("FAIL fill_peak: got %0d expected 16", rlevel); end
`endif
    rinc = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      n_checks += 4;
      if (raddr !== 4'(rd_tot % DEPTH)) begin n_fail++; $display("FAIL drain_raddr pop %0d: got %0d expected %0d", i, raddr, rd_tot % DEPTH); end
      if (rptr_g !== gray_of(rd_tot)) begin n_fail++; $display("FAIL drain_rptr_g pop %0d: got %b expected %b", i, rptr_g, gray_of(rd_tot)); end
      if (rempty !== m_empty) begin n_fail++; $display("FAIL drain_rempty pop %0d: got %b expected %b", i, rempty, m_empty); end
      if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL drain_rlevel pop %0d: got %0d expected %0d", i, rlevel, exp_level()); end
    end
    rinc = 1'b0;
    n_checks += 4;
    if (rempty !== 1'b1)    begin n_fail++; $display("FAIL drain_final_rempty: got %b expected 1", rempty); end
    if (raddr !== 4'd0)     begin n_fail++; $display("FAIL drain_wrap_raddr: got %0d expected 0", raddr); end
    if (rptr_g[4] !== 1'b1) begin n_fail++; $display("FAIL drain_msb_toggle: got %b expected 1", rptr_g[4]); end
    if (runderflow !== 1'b0) begin n_fail++; $display("FAIL drain_no_underflow: got %b expected 0", runderflow); end
  endtask

  task automatic test_almost_empty();
    apply_reset();
    for (int i = 1; i <= 4 + SYNC_STAGES; i++) begin
      if (i <= 4) set_w(i);
      tick();
    end
    n_checks += 2;
    if (ralmost_empty !== exp_ae()) begin n_fail++; $display("FAIL ae_level4: got %b expected %b", ralmost_empty, exp_ae()); end
    if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL ae_rlevel4: got %0d expected %0d", rlevel, exp_level()); end
    rinc = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_checks += 3;
      if (ralmost_empty !== exp_ae()) begin n_fail++; $display("FAIL ae_pop %0d: got %b expected %b", i, ralmost_empty, exp_ae()); end
      if (rempty !== 1'b0) begin n_fail++; $display("FAIL ae_rempty pop %0d: got %b expected 0", i, rempty); end
      if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL ae_rlevel pop %0d: got %0d expected %0d", i, rlevel, exp_level()); end
    end
    rinc = 1'b0;
  endtask

  task automatic test_underflow();
    apply_reset();
    rinc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks += 3;
      if (raddr !== 4'd0)      begin n_fail++; $display("FAIL uflow_raddr cycle %0d: got %0d expected 0", i, raddr); end
      if (rptr_g !== 5'd0)     begin n_fail++; $display("FAIL uflow_rptr_g cycle %0d: got %b expected 00000", i, rptr_g); end
      if (runderflow !== 1'b1) begin n_fail++; $display("FAIL uflow_set cycle %0d: got %b expected 1", i, runderflow); end
    end
    rinc = 1'b0;
    set_w(2);
    repeat (SYNC_STAGES + 2) tick();
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    tick();
    n_checks += 3;
    if (runderflow !== m_uflow) begin n_fail++; $display("FAIL uflow_sticky: got %b expected %b", runderflow, m_uflow); end
    if (raddr !== 4'd1)     begin n_fail++; $display("FAIL uflow_pop_raddr: got %0d expected 1", raddr); end
    if (rempty !== 1'b0)    begin n_fail++; $display("FAIL uflow_pop_rempty: got %b expected 0", rempty); end
    // Asynchronous clear, checked before any further clock edge.
    rrst_n = 1'b0;
    #2;
    n_checks += 6;
    if (runderflow !== 1'b0)    begin n_fail++; $display("FAIL async_rst_runderflow: got %b expected 0", runderflow); end
    if (raddr !== 4'd0)         begin n_fail++; $display("FAIL async_rst_raddr: got %0d expected 0", raddr); end
    if (rptr_g !== 5'd0)        begin n_fail++; $display("FAIL async_rst_rptr_g: got %b expected 00000", rptr_g); end
    if (rempty !== 1'b1)        begin n_fail++; $display("FAIL async_rst_rempty: got %b expected 1", rempty); end
    if (ralmost_empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_ralmost_empty: got %b expected 1", ralmost_empty); end
    if (rlevel !== 5'd0)        begin n_fail++; $display("FAIL async_rst_rlevel: got %0d expected 0", rlevel); end
    apply_reset();
  endtask

  task automatic test_level_config();
    apply_reset();
    for (int i = 1; i <= 5 + SYNC_STAGES; i++) begin
      if (i <= 5) set_w(i);
      tick();
    end
    rinc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      n_checks += 3;
      if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL cfg_rlevel step %0d: got %0d expected %0d", i, rlevel, exp_level()); end
      if (ralmost_empty !== exp_ae()) begin n_fail++; $display("FAIL cfg_ralmost_empty step %0d: got %b expected %b", i, ralmost_empty, exp_ae()); end
      if (rempty !== m_empty) begin n_fail++; $display("FAIL cfg_rempty step %0d: got %b expected %b", i, rempty, m_empty); end
      tick();
    end
    rinc = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      // Alternate write-heavy and read-heavy phases so both full and empty are visited.
      bit write_heavy = ((c / 60) % 2) == 0;
      if ($urandom_range(0, 3) < (write_heavy ? 3 : 1) && (w_tot - rd_tot) < DEPTH) set_w(w_tot + 1);
      rinc = ($urandom_range(0, 3) < (write_heavy ? 1 : 3));
      tick();
      n_checks += 7;
      if (rempty !== m_empty) begin n_fail++; $display("FAIL rnd_rempty cyc %0d: got %b expected %b", c, rempty, m_empty); end
      if (rlevel !== 5'(exp_level())) begin n_fail++; $display("FAIL rnd_rlevel cyc %0d: got %0d expected %0d", c, rlevel, exp_level()); end
      if (ralmost_empty !== exp_ae()) begin n_fail++; $display("FAIL rnd_ralmost_empty cyc %0d: got %b expected %b", c, ralmost_empty, exp_ae()); end
      if (raddr !== 4'(rd_tot % DEPTH)) begin n_fail++; $display("FAIL rnd_raddr cyc %0d: got %0d expected %0d", c, raddr, rd_tot % DEPTH); end
      if (rptr_g !== gray_of(rd_tot)) begin n_fail++; $display("FAIL rnd_rptr_g cyc %0d: got %b expected %b", c, rptr_g, gray_of(rd_tot)); end
      if (runderflow !== m_uflow) begin n_fail++; $display("FAIL rnd_runderflow cyc %0d: got %b expected %b", c, runderflow, m_uflow); end
      if (w_tot - rd_tot > DEPTH) begin n_fail++; $display("FAIL rnd_occupancy cyc %0d: got %0d expected <= %0d", c, w_tot - rd_tot, DEPTH); end
    end
    rinc = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sync_latency();
    test_fill_drain();
    test_almost_empty();
    test_underflow();
    test_level_config();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
